// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider / button front end: button bit
// indices, default divide and debounce constants, and a counter-width helper.
// No logic, no ports.
package clock_divider_pkg;

  localparam int NUM_BUTTONS = 5;

  // Bit positions within the Buttons / Pressed / PressedPulse vectors.
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_CENTER = 4;

  typedef logic [NUM_BUTTONS-1:0] buttons_t;

  // Defaults tuned for a 100 MHz master clock.
  localparam int DEF_MASTER_HZ       = 100_000_000;
  localparam int DEF_CLOCK_DIV       = 4;
  localparam int DEF_FAST_DIV        = 131072;      // ~763 Hz display refresh
  localparam int DEF_GAME_DIV        = 25_000_000;  // 4 Hz game step
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms

  // Bits needed to hold 0..n-1; never returns zero so a divide-by-2 or a
  // minimal debounce window still gets a real (1-bit) counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Bundle of the button inputs and the divided-clock / debounced outputs.
// slave: seen by clock_divider (Buttons in, everything else out).
// master: seen by the surrounding logic or a bench (drives Buttons).
interface clock_divider_if;
  import clock_divider_pkg::*;

  buttons_t Buttons;       // raw asynchronous buttons
  logic     Clock;         // MasterClock / CLOCK_DIV
  logic     fastClock;     // MasterClock / FAST_DIV
  logic     gameClock;     // MasterClock / GAME_DIV
  buttons_t Pressed;       // debounced levels
  buttons_t PressedPulse;  // one-cycle strobe per debounced press

  modport slave (
    input  Buttons,
    output Clock, fastClock, gameClock, Pressed, PressedPulse
  );

  modport master (
    output Buttons,
    input  Clock, fastClock, gameClock, Pressed, PressedPulse
  );

endinterface

// File: rtl/clock_divider_debouncer.sv
// One-button debouncer: 2-flop synchronizer, stability counter, level, press strobe.
// Latency: clean raw edge to pressed change is 2 + DEBOUNCE_CYCLES clk cycles.
// Backpressure: none; free-running, raw is sampled every cycle.
// Ports: clk, rst_n (async active-low), raw (async button), pressed (level),
//        pulse (high for the single cycle in which pressed goes 0->1).
module debouncer
  import clock_divider_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pressed,
  output logic pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      pressed   <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      pulse     <= 1'b0;
      if (sync == pressed) begin
        // Agreement (or a glitch ending early) throws away partial progress.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Disagreement has lasted DEBOUNCE_CYCLES cycles: accept it.
        cnt     <= '0;
        pressed <= sync;
        pulse   <= sync;  // strobe only on a press, never on a release
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Three independent 50%-duty clock dividers plus five debounced buttons.
// Latency: divided outputs first rise on edge DIV/2 after reset; buttons 2+DEBOUNCE_CYCLES.
// Backpressure: none; all outputs are free-running registered signals.
// Ports: MasterClock (sole clock), ResetN (async active-low), io (slave modport:
//        Buttons in; Clock, fastClock, gameClock, Pressed, PressedPulse out).
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int MASTER_HZ       = DEF_MASTER_HZ,  // nominal, informational
  parameter int CLOCK_DIV       = DEF_CLOCK_DIV,
  parameter int FAST_DIV        = DEF_FAST_DIV,
  parameter int GAME_DIV        = DEF_GAME_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic            MasterClock,
  input  logic            ResetN,
  clock_divider_if.slave  io
);

  // Reject divide ratios that cannot give a 50% duty output.
  if (MASTER_HZ < 1 || CLOCK_DIV < 2 || (CLOCK_DIV % 2) != 0 ||
      FAST_DIV < 2 || (FAST_DIV % 2) != 0 ||
      GAME_DIV < 2 || (GAME_DIV % 2) != 0 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("clock_divider: illegal parameter set");
  end

  // ---------------- Clock: MasterClock / CLOCK_DIV ----------------
  localparam int CLK_HALF = CLOCK_DIV / 2;
  localparam int CLK_W    = cnt_width(CLK_HALF);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLK_HALF - 1);

  logic [CLK_W-1:0] clk_cnt;
  logic             clk_q;

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      clk_cnt <= '0;
      clk_q   <= 1'b0;
    end else if (clk_cnt == CLK_LAST) begin
      clk_cnt <= '0;
      clk_q   <= ~clk_q;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // ---------------- fastClock: MasterClock / FAST_DIV ----------------
  localparam int FAST_HALF = FAST_DIV / 2;
  localparam int FAST_W    = cnt_width(FAST_HALF);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);

  logic [FAST_W-1:0] fast_cnt;
  logic              fast_q;

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      fast_cnt <= '0;
      fast_q   <= 1'b0;
    end else if (fast_cnt == FAST_LAST) begin
      fast_cnt <= '0;
      fast_q   <= ~fast_q;
    end else begin
      fast_cnt <= fast_cnt + 1'b1;
    end
  end

  // ---------------- gameClock: MasterClock / GAME_DIV ----------------
  localparam int GAME_HALF = GAME_DIV / 2;
  localparam int GAME_W    = cnt_width(GAME_HALF);
  localparam logic [GAME_W-1:0] GAME_LAST = GAME_W'(GAME_HALF - 1);

  logic [GAME_W-1:0] game_cnt;
  logic              game_q;

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      game_cnt <= '0;
      game_q   <= 1'b0;
    end else if (game_cnt == GAME_LAST) begin
      game_cnt <= '0;
      game_q   <= ~game_q;
    end else begin
      game_cnt <= game_cnt + 1'b1;
    end
  end

  assign io.Clock     = clk_q;
  assign io.fastClock = fast_q;
  assign io.gameClock = game_q;

  // ---------------- Buttons: one debouncer each ----------------
  buttons_t pressed;
  buttons_t pulse;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (MasterClock),
      .rst_n   (ResetN),
      .raw     (io.Buttons[b]),
      .pressed (pressed[b]),
      .pulse   (pulse[b])
    );
  end

  assign io.Pressed      = pressed;
  assign io.PressedPulse = pulse;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider with small divide/debounce constants. A reference
// model derives divided clocks from the edge count since reset release and
// button levels from a history window of raw samples.
module tb_clock_divider;
  import clock_divider_pkg::*;

  localparam int CDIV = 4;
  localparam int FDIV = 8;
  localparam int GDIV = 16;
  localparam int DEB  = 5;
  localparam int LAT  = 2 + DEB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_divider_if bus();

  clock_divider #(
    .MASTER_HZ       (100_000_000),
    .CLOCK_DIV       (CDIV),
    .FAST_DIV        (FDIV),
    .GAME_DIV        (GDIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .MasterClock (clk),
    .ResetN      (rst_n),
    .io          (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int       n;                       // rising edges since reset release
  bit [4:0] hist[$];                 // raw Buttons seen at edge k is hist[k-1]
  bit [4:0] m_pressed;
  bit [4:0] m_pulse;
  int       last_flip[NUM_BUTTONS];  // edge at which each level last changed

  // The synchronized value used at edge e is the raw value from edge e-2
  // (zero for the first two edges after release). A level changes at edge n
  // when the DEB most recent synchronized samples, all after its last change,
  // disagree with the current level.
  function automatic bit settled(input int i);
    int e;
    bit s;
    for (int k = 0; k < DEB; k++) begin
      e = n - k;
      if (e <= last_flip[i]) return 1'b0;
      s = (e >= 3) ? hist[e-3][i] : 1'b0;
      if (s == m_pressed[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit div_exp(input int div);
    return ((n / (div / 2)) % 2) == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      hist.delete();
      m_pressed = '0;
      m_pulse   = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) last_flip[i] = 0;
    end else begin
      n = n + 1;
      hist.push_back(bus.Buttons);
      m_pulse = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (settled(i)) begin
          m_pressed[i] = ~m_pressed[i];
          m_pulse[i]   = m_pressed[i];
          last_flip[i] = n;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge clk);
    cmp("Clock",        {4'b0, bus.Clock},     {4'b0, div_exp(CDIV)});
    cmp("fastClock",    {4'b0, bus.fastClock}, {4'b0, div_exp(FDIV)});
    cmp("gameClock",    {4'b0, bus.gameClock}, {4'b0, div_exp(GDIV)});
    cmp("Pressed",      bus.Pressed,           m_pressed);
    cmp("PressedPulse", bus.PressedPulse,      m_pulse);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, " Clock"},        {4'b0, bus.Clock},     5'b0);
    cmp({tag, " fastClock"},    {4'b0, bus.fastClock}, 5'b0);
    cmp({tag, " gameClock"},    {4'b0, bus.gameClock}, 5'b0);
    cmp({tag, " Pressed"},      bus.Pressed,           5'b0);
    cmp({tag, " PressedPulse"}, bus.PressedPulse,      5'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int first_clk;
    int seen;

    bus.Buttons = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Free-running dividers after release.
    rst_n = 1'b1;
    repeat (64) step();

    // Center press held: level after LAT cycles, single pulse.
    bus.Buttons[BTN_CENTER] = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.Pressed[BTN_CENTER] && lat < 20);
    cmp_int("center latency", lat, LAT);
    cmp("center pulse", {4'b0, bus.PressedPulse[BTN_CENTER]}, 5'b1);
    seen = 0;
    repeat (12) begin
      step();
      seen += int'(bus.PressedPulse[BTN_CENTER]);
    end
    cmp_int("center held extra pulses", seen, 0);

    // Four-cycle glitch on Left must be rejected.
    bus.Buttons[BTN_LEFT] = 1'b1;
    seen = 0;
    repeat (4) begin
      step();
      seen += int'(bus.Pressed[BTN_LEFT] | bus.PressedPulse[BTN_LEFT]);
    end
    bus.Buttons[BTN_LEFT] = 1'b0;
    repeat (12) begin
      step();
      seen += int'(bus.Pressed[BTN_LEFT] | bus.PressedPulse[BTN_LEFT]);
    end
    cmp_int("left glitch activity", seen, 0);

    // Up and Down together.
    bus.Buttons[BTN_UP]   = 1'b1;
    bus.Buttons[BTN_DOWN] = 1'b1;
    repeat (LAT) step();
    cmp("up/down pressed", {3'b0, bus.Pressed[BTN_DOWN], bus.Pressed[BTN_UP]}, 5'b00011);
    cmp("up/down pulse", {3'b0, bus.PressedPulse[BTN_DOWN], bus.PressedPulse[BTN_UP]}, 5'b00011);
    repeat (5) step();
    bus.Buttons[BTN_UP]   = 1'b0;
    bus.Buttons[BTN_DOWN] = 1'b0;
    repeat (LAT - 1) step();
    cmp("up/down before release", {3'b0, bus.Pressed[BTN_DOWN], bus.Pressed[BTN_UP]}, 5'b00011);
    step();
    cmp("up/down released", {3'b0, bus.Pressed[BTN_DOWN], bus.Pressed[BTN_UP]}, 5'b00000);
    cmp("up/down release pulse", {3'b0, bus.PressedPulse[BTN_DOWN], bus.PressedPulse[BTN_UP]}, 5'b00000);

    // Reset mid-debounce (Right) and mid-divide, buttons held through it.
    bus.Buttons[BTN_RIGHT] = 1'b1;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1 chk_zero("async reset");
    repeat (3) step();
    rst_n = 1'b1;
    lat = 0;
    first_clk = 0;
    do begin
      step();
      lat++;
      if (bus.Clock && first_clk == 0) first_clk = lat;
    end while (!bus.Pressed[BTN_RIGHT] && lat < 20);
    cmp_int("right latency after reset", lat, LAT);
    cmp_int("first Clock rise after reset", first_clk, CDIV / 2);
    cmp("held center after reset", {4'b0, bus.Pressed[BTN_CENTER]}, 5'b1);

    // Random button activity with glitches of varied length.
    repeat (400) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if ($urandom_range(0, 5) == 0) bus.Buttons[i] = ~bus.Buttons[i];
      end
      step();
    end
    bus.Buttons = '0;
    repeat (20) step();
    cmp("all released", bus.Pressed, 5'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
